// File: rtl/vga_timing_controller.sv
// VGA raster sequencer: pixel-rate tick, h/v counters, sync/blank decodes and line/frame strobes.
// Optional: define VGA_FRAME_COUNT_EN to add a 16-bit frame_count output.
module vga_timing_controller #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  output logic        pix_tick,
  output logic [15:0] h_count,
  output logic [15:0] v_count,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic        line_end,
  output logic        frame_start
`ifdef VGA_FRAME_COUNT_EN
  ,
  output logic [15:0] frame_count
`endif
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

  localparam logic [15:0] H_ACT_LAST  = 16'(H_ACTIVE - 1);
  localparam logic [15:0] H_FP_LAST   = 16'(H_ACTIVE + H_FP - 1);
  localparam logic [15:0] H_SYNC_LAST = 16'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [15:0] H_LAST      = 16'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);

  localparam logic [15:0] V_ACT       = 16'(V_ACTIVE);
  localparam logic [15:0] V_SYNC_LO   = 16'(V_ACTIVE + V_FP);
  localparam logic [15:0] V_SYNC_HI   = 16'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [15:0] V_LAST      = 16'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  typedef enum logic [1:0] {H_ACT, H_FRONT, H_SYNC_ST, H_BACK} h_state_t;

  h_state_t         h_state, h_state_next;
  logic [DIV_W-1:0] div_cnt;
  logic             advance, h_wrap, v_wrap;
  logic [15:0]      h_next, v_next;

  // Next-count view: the registered decodes below are computed from these so
  // they line up with the counts presented in the same cycle.
  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    advance      = enable && (div_cnt == DIV_MAX);
    h_wrap       = advance && (h_count == H_LAST);
    v_wrap       = h_wrap && (v_count == V_LAST);
    h_next       = h_count;
    v_next       = v_count;
    h_state_next = h_state;

    if (advance) begin
      h_next = h_wrap ? 16'd0 : h_count + 16'd1;
      unique case (h_state)
        H_ACT:     if (h_count == H_ACT_LAST)  h_state_next = H_FRONT;
        H_FRONT:   if (h_count == H_FP_LAST)   h_state_next = H_SYNC_ST;
        H_SYNC_ST: if (h_count == H_SYNC_LAST) h_state_next = H_BACK;
        H_BACK:    if (h_wrap)                 h_state_next = H_ACT;
      endcase
    end

    if (h_wrap) begin
      v_next = v_wrap ? 16'd0 : v_count + 16'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt     <= '0;
      h_state     <= H_ACT;
      h_count     <= 16'd0;
      v_count     <= 16'd0;
      pix_tick    <= 1'b0;
      line_end    <= 1'b0;
      frame_start <= 1'b0;
      video_on    <= 1'b0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
`ifdef VGA_FRAME_COUNT_EN
      frame_count <= 16'd0;
`endif
    end else begin
      div_cnt     <= (advance || !enable) ? '0 : div_cnt + DIV_W'(1);
      h_state     <= h_state_next;
      h_count     <= h_next;
      v_count     <= v_next;
      pix_tick    <= advance;
      line_end    <= h_wrap;
      frame_start <= v_wrap;
      // Sync levels follow the held position while disabled; only video_on drops.
      video_on    <= enable && (h_state_next == H_ACT) && (v_next < V_ACT);
      hsync       <= (h_state_next == H_SYNC_ST) ? SYNC_POL : ~SYNC_POL;
      vsync       <= ((v_next >= V_SYNC_LO) && (v_next < V_SYNC_HI)) ? SYNC_POL : ~SYNC_POL;
`ifdef VGA_FRAME_COUNT_EN
      if (frame_start) frame_count <= frame_count + 16'd1;
`endif
    end
  end

endmodule

// File: tb/tb_vga_timing_controller.sv
// Scoreboard bench for vga_timing_controller on a reduced 16x10 raster with CLK_DIV=2.
module tb_vga_timing_controller;

  localparam int CLK_DIV  = 2;
  localparam int H_ACTIVE = 8;
  localparam int H_FP     = 2;
  localparam int H_SYNC   = 3;
  localparam int H_BP     = 3;
  localparam int V_ACTIVE = 4;
  localparam int V_FP     = 2;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 2;
  localparam bit SYNC_POL = 1'b0;
  localparam int H_TOTAL  = 16;
  localparam int V_TOTAL  = 10;
  localparam int WIN      = 640;  // two full frames of clocks

  logic        clk, rst_n, enable;
  logic        pix_tick, hsync, vsync, video_on, line_end, frame_start;
  logic [15:0] h_count, v_count;
`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] frame_count;
`endif

  vga_timing_controller #(
    .CLK_DIV(CLK_DIV), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP), .SYNC_POL(SYNC_POL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .pix_tick(pix_tick),
    .h_count(h_count), .v_count(v_count), .hsync(hsync), .vsync(vsync),
    .video_on(video_on), .line_end(line_end), .frame_start(frame_start)
`ifdef VGA_FRAME_COUNT_EN
    , .frame_count(frame_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        pix_tick;
    logic [15:0] h;
    logic [15:0] v;
    logic        hsync;
    logic        vsync;
    logic        video_on;
    logic        line_end;
    logic        frame_start;
  } obs_t;

  obs_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain arithmetic on pixel/line positions, one step per clock edge.
  int m_div = 0, m_h = 0, m_v = 0;
  int m_fc = 0;
  bit m_prev_fs = 1'b0;

  task automatic model_step();
    obs_t e;
    bit   tick;
    e = '0;
    if (!rst_n) begin
      m_div = 0; m_h = 0; m_v = 0; m_fc = 0;
    end else begin
      if (m_prev_fs) m_fc = (m_fc + 1) % 65536;
      if (enable) begin
        tick  = (m_div == CLK_DIV - 1);
        m_div = tick ? 0 : m_div + 1;
        if (tick) begin
          e.pix_tick = 1'b1;
          m_h++;
          if (m_h == H_TOTAL) begin
            m_h = 0;
            e.line_end = 1'b1;
            m_v++;
            if (m_v == V_TOTAL) begin
              m_v = 0;
              e.frame_start = 1'b1;
            end
          end
        end
        e.video_on = (m_h < H_ACTIVE) && (m_v < V_ACTIVE);
      end else begin
        m_div = 0;
      end
    end
    m_prev_fs = e.frame_start;
    e.h     = 16'(m_h);
    e.v     = 16'(m_v);
    e.hsync = (m_h >= H_ACTIVE + H_FP && m_h < H_ACTIVE + H_FP + H_SYNC) ? SYNC_POL : !SYNC_POL;
    e.vsync = (m_v >= V_ACTIVE + V_FP && m_v < V_ACTIVE + V_FP + V_SYNC) ? SYNC_POL : !SYNC_POL;
    sb.push_back(e);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Monitor: pops one expectation per clock and tallies pulses over a two-frame window.
  bit win_start = 1'b0;
  int win_n = 0;
  int n_tick = 0, n_le = 0, n_fs = 0, n_hs = 0, n_vs = 0, n_vid = 0;

  initial forever begin
    obs_t exp_o, act_o;
    @(negedge clk);
    if (sb.size() > 0) begin
      exp_o = sb.pop_front();
      act_o = {pix_tick, h_count, v_count, hsync, vsync, video_on, line_end, frame_start};
      check("raster", 64'(act_o), 64'(exp_o));
    end
    if (win_start) begin
      if (win_n >= 1 && win_n <= WIN) begin
        n_tick += int'(pix_tick);
        n_le   += int'(line_end);
        n_fs   += int'(frame_start);
        n_hs   += int'(hsync == SYNC_POL);
        n_vs   += int'(vsync == SYNC_POL);
        n_vid  += int'(video_on);
      end
      win_n++;
    end
  end

  initial begin
    rst_n  = 1'b0;
    enable = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("idle_hold", 64'({pix_tick, h_count, v_count, hsync, vsync, video_on}),
          64'({1'b0, 16'd0, 16'd0, 1'b1, 1'b1, 1'b0}));

    @(posedge clk);
    #1 enable = 1'b1; win_start = 1'b1;
    @(posedge clk); @(negedge clk);
    check("first_clk", 64'({pix_tick, h_count, video_on}), 64'({1'b0, 16'd0, 1'b1}));
    @(negedge clk);
    check("first_tick", 64'({pix_tick, h_count, v_count}), 64'({1'b1, 16'd1, 16'd0}));

    // 714 enabled edges -> 357 ticks -> position (5,2) in frame 3.
    repeat (712) @(posedge clk);
    #1 enable = 1'b0;
    check("win_ticks",   64'(n_tick), 64'(320));
    check("win_line_end", 64'(n_le),  64'(20));
    check("win_frame",   64'(n_fs),   64'(2));
    check("win_hsync",   64'(n_hs),   64'(120));
    check("win_vsync",   64'(n_vs),   64'(128));
    check("win_video",   64'(n_vid),  64'(128));

    repeat (50) @(posedge clk);
    @(negedge clk);
    check("hold_pos", 64'({pix_tick, h_count, v_count, video_on, line_end}),
          64'({1'b0, 16'd5, 16'd2, 1'b0, 1'b0}));
    @(posedge clk);
    #1 enable = 1'b1;
    @(posedge clk); @(negedge clk);
    check("resume_wait", 64'({pix_tick, h_count, video_on}), 64'({1'b0, 16'd5, 1'b1}));
    @(negedge clk);
    check("resume_tick", 64'({pix_tick, h_count, v_count}), 64'({1'b1, 16'd6, 16'd2}));

    // 85 more ticks -> (11,7): inside both sync pulses.
    repeat (170) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("pre_reset", 64'({h_count, v_count, hsync, vsync}), 64'({16'd11, 16'd7, 1'b0, 1'b0}));
    @(posedge clk); @(negedge clk);
    check("mid_reset", 64'({pix_tick, h_count, v_count, hsync, vsync, video_on, frame_start}),
          64'({1'b0, 16'd0, 16'd0, 1'b1, 1'b1, 1'b0, 1'b0}));
    rst_n = 1'b1;
    repeat (400) @(posedge clk);
    @(negedge clk);
`ifdef VGA_FRAME_COUNT_EN
    check("frame_count", 64'(frame_count), 64'(m_fc));
`endif
    check("sb_drained", 64'(sb.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vga_timing_controller.md
Name: vga_timing_controller

Overview:
- Sequences the VGA raster. Generates the pixel-rate tick and the horizontal and vertical counters, with the vertical counter wrapping at 524.
- Derives hsync, vsync, video_on and line/frame strobes from the counters.
- Sits between the system clock and the pixel generator. All downstream video logic uses its tick, counts and strobes and does not keep counters of its own.

Parameters:
CLK_DIV, 2, system clocks per pixel (>=1)
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch
H_SYNC, 96, horizontal sync width
H_BP, 48, horizontal back porch
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch
V_SYNC, 2, vertical sync width
V_BP, 33, vertical back porch
SYNC_POL, 0, sync assertion level (0 = active-low)

Ports:
clk  in  1  system clock, all logic on posedge
rst_n  in  1  synchronous active-low reset
enable  in  1  run/hold control for the raster
pix_tick  out  1  one-clk pulse every CLK_DIV clocks
h_count  out  16  horizontal position, 0..H_TOTAL-1
v_count  out  16  vertical position, 0..V_TOTAL-1
hsync  out  1  horizontal sync
vsync  out  1  vertical sync
video_on  out  1  high inside the visible region
line_end  out  1  one-clk pulse when h_count wraps to 0
frame_start  out  1  one-clk pulse when (h,v) wraps to (0,0)

Behaviour:
- Interface: one clock; reset is synchronous and active-low. Ports are clk and rst_n; rst_n is sampled only on posedge clk.
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800). V_TOTAL likewise (525). All compares are unsigned, 16-bit.
- Reset values:
  - div counter, h_count, v_count = 0.
  - pix_tick, video_on, line_end, frame_start = 0.
  - hsync, vsync = deasserted (~SYNC_POL).
- Divider: counts 0..CLK_DIV-1 while enable=1. pix_tick=1 in the clk after the divider reaches CLK_DIV-1, so the first tick comes CLK_DIV clocks after enable rises. With CLK_DIV=1, pix_tick is high every clk while enabled.
- Horizontal FSM (internal), with states H_ACT, H_FRONT, H_SYNC_ST and H_BACK:
  - Each state advances on the pix_tick where h_count reaches its phase boundary: 639->FRONT, 655->SYNC, 751->BACK, 799->ACT.
  - h_count increments on each pix_tick and wraps H_TOTAL-1 -> 0.
- Vertical: v_count increments only on the pix_tick where h_count wraps. It wraps V_TOTAL-1 -> 0 (524 -> 0 at defaults).
- Registered decodes, updated every clk from the next-count values so they are aligned with the h_count/v_count presented in the same cycle:
  - hsync = SYNC_POL when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vsync = SYNC_POL when V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC (490..491).
  - video_on = enable & (h < H_ACTIVE) & (v < V_ACTIVE).
- line_end is high for exactly the one clk in which h_count first reads 0 after a wrap. frame_start is high for the one clk in which (h,v) first reads (0,0) after a wrap. Neither pulses after reset.
- enable=0:
  - Divider clears to 0; h_count and v_count hold; pix_tick, line_end and frame_start stay 0.
  - video_on goes 0 on the next clk; hsync and vsync hold their decoded values.
  - Re-asserting enable resumes from the held position.
- Reset mid-frame: every output returns to its reset value on the next edge, regardless of enable or FSM state.
- Simultaneous h and v wrap: line_end and frame_start assert in the same clk.

Optional Feature:
- Macro: VGA_FRAME_COUNT_EN.
- Defined: adds output frame_count [15:0].
  - Reset value 0.
  - Increments in the clk where frame_start is high; wraps 65535 -> 0.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
- Reset then enable=1, CLK_DIV=2 -> first pix_tick 2 clks after enable; h_count=1 after the first tick; video_on=1 from the first clk after enable.
- Run one line -> h_count 0..799; line_end once every 1600 clks; hsync low exactly for h=656..751 (96 ticks, 192 clks); video_on low from h=640.
- Run full frame -> v_count 0..524 then 0; vsync low for v=490..491 (1600 clks each); frame_start once every 840000 clks, coincident with line_end.
- Drop enable at h=300, v=100 for 50 clks -> counts hold at (300,100); no ticks; video_on=0; after re-enable, counting resumes at 301 after CLK_DIV clks.
- Assert rst_n=0 at h=700, v=491 -> next edge: counts 0, hsync=1, vsync=1, video_on=0; no frame_start after release.
- With VGA_FRAME_COUNT_EN and CLK_DIV=1 -> frame_count=3 after 3*420000 clks of enable; without the macro the port is absent and the build is clean.
